// File: rtl/otter_mem_pkg.sv
// otter_mem_pkg: shared types and constants for the OTTER handshake memory
package otter_mem_pkg;
  localparam int MEM_WORD_BYTES = 4;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_t;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} mem_state_t;
endpackage

// File: rtl/otter_mem_lane.sv
// otter_mem_lane: byte-lane steering for stores and extraction/extension for loads
import otter_mem_pkg::*;
module otter_mem_lane (
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sign,
  input  logic [31:0] din,
  input  logic [31:0] rdata,
  output logic        valid,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rout
);
  logic [31:0] sh;
  always_comb begin
    valid = (size == SZ_BYTE) || (size == SZ_HALF && off != 2'd3) || (size == SZ_WORD && off == 2'd0);
    be = !valid ? 4'b0000 : size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? 4'b0011 << off : 4'b1111;
    wdata = din << {off, 3'b000};
    sh = rdata >> {off, 3'b000};
    rout = !valid ? 32'h0 :
           size == SZ_BYTE ? {{24{~sign & sh[7]}}, sh[7:0]} :
           size == SZ_HALF ? {{16{~sign & sh[15]}}, sh[15:0]} : sh;
  end
endmodule

// File: rtl/otter_mem_hs.sv
// otter_mem_hs: OTTER BRAM with sync instruction port and req/ack data port with wait states and MMIO.
// Define OTTER_MEM_ERR_EN to add MEM_ERR flagging of unsupported size/offset and hole accesses.
import otter_mem_pkg::*;
module otter_mem_hs #(
  parameter int          ADDR_WIDTH  = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] IO_BASE     = 32'h0001_0000,
  parameter              INIT_FILE   = ""
) (
  input  logic                  MEM_CLK,
  input  logic                  MEM_RST,
  input  logic                  MEM_RDEN1,
  input  logic [ADDR_WIDTH-3:0] MEM_ADDR1,
  output logic [31:0]           MEM_DOUT1,
  input  logic                  MEM_REQ2,
  input  logic                  MEM_WE2,
  input  logic [31:0]           MEM_ADDR2,
  input  logic [31:0]           MEM_DIN2,
  input  logic [1:0]            MEM_SIZE,
  input  logic                  MEM_SIGN,
  output logic                  MEM_BUSY2,
  output logic                  MEM_ACK2,
  output logic [31:0]           MEM_DOUT2,
  input  logic [31:0]           IO_IN,
  output logic                  IO_WR
`ifdef OTTER_MEM_ERR_EN
  , output logic                MEM_ERR
`endif
);
  localparam int DEPTH = (1 << ADDR_WIDTH) / MEM_WORD_BYTES;
  localparam logic [32:0] RAM_BYTES = 33'd1 << ADDR_WIDTH;
  logic [31:0] ram [DEPTH];
  mem_state_t state;
  logic [3:0] cnt;
  logic we_q, sign_q;
  logic [31:0] addr_q, din_q;
  logic [1:0] size_q;
  logic in_ram, in_io, valid;
  logic [3:0] be;
  logic [31:0] wdata, rout;
  assign in_ram = {1'b0, addr_q} < RAM_BYTES;
  assign in_io = addr_q >= IO_BASE;
  otter_mem_lane u_lane (
    .size(size_q), .off(addr_q[1:0]), .sign(sign_q), .din(din_q),
    .rdata(ram[addr_q[ADDR_WIDTH-1:2]]),
    .valid(valid), .be(be), .wdata(wdata), .rout(rout)
  );
  always_ff @(posedge MEM_CLK)
    if (MEM_RST)
      MEM_DOUT1 <= 32'h0;
    else if (MEM_RDEN1)
      MEM_DOUT1 <= ram[MEM_ADDR1];
  // a store whose commit edge coincides with reset is abandoned
  always_ff @(posedge MEM_CLK)
    if (!MEM_RST && state == ACCESS && we_q && in_ram)
      for (int i = 0; i < 4; i++)
        if (be[i]) ram[addr_q[ADDR_WIDTH-1:2]][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge MEM_CLK) begin
    if (MEM_RST) begin
      state <= IDLE;
      cnt <= 4'd0;
      MEM_BUSY2 <= 1'b0;
      MEM_ACK2 <= 1'b0;
      MEM_DOUT2 <= 32'h0;
      IO_WR <= 1'b0;
`ifdef OTTER_MEM_ERR_EN
      MEM_ERR <= 1'b0;
`endif
    end else begin
      MEM_ACK2 <= 1'b0;
      IO_WR <= 1'b0;
`ifdef OTTER_MEM_ERR_EN
      MEM_ERR <= 1'b0;
`endif
      case (state)
        IDLE: if (MEM_REQ2) begin
          we_q <= MEM_WE2;
          addr_q <= MEM_ADDR2;
          din_q <= MEM_DIN2;
          size_q <= MEM_SIZE;
          sign_q <= MEM_SIGN;
          cnt <= 4'(WAIT_STATES);
          MEM_BUSY2 <= 1'b1;
          state <= (WAIT_STATES == 0) ? ACCESS : WAIT;
          IO_WR <= (WAIT_STATES == 0) && MEM_WE2 && (MEM_ADDR2 >= IO_BASE);
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ACCESS;
            IO_WR <= we_q && in_io;
          end
        end
        ACCESS: begin
          state <= RESP;
          MEM_ACK2 <= 1'b1;
          if (!we_q) MEM_DOUT2 <= in_io ? IO_IN : in_ram ? rout : 32'h0;
`ifdef OTTER_MEM_ERR_EN
          MEM_ERR <= (!in_ram && !in_io) || !valid;
`endif
        end
        default: begin
          state <= IDLE;
          MEM_BUSY2 <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_otter_mem_hs.sv
// tb_otter_mem_hs: directed checks of two instances (0 and 3 wait states) fed the same data-port stream
module tb_otter_mem_hs;
  logic clk = 0, rst = 1, rden1 = 0, req = 0, we = 0, sign = 0;
  logic [13:0] addr1 = 0;
  logic [31:0] addr2 = 0, din2 = 0, io_in = 0;
  logic [1:0] size = 0;
  logic [31:0] d1_a, d1_b, dout_a, dout_b;
  logic busy_a, busy_b, ack_a, ack_b, iowr_a, iowr_b, err_a, err_b;
  int total = 0, bad = 0;
  int r_la, r_lb, r_ba, r_bb, r_ia, r_ib, r_ica, r_icb, acks;
  logic [31:0] r_da, r_db;
  logic r_ea, r_eb;
  logic [31:0] p1a [0:8], p1b [0:8];
  always #5 clk = ~clk;
  otter_mem_hs #(.WAIT_STATES(0)) dut_a (
    .MEM_CLK(clk), .MEM_RST(rst), .MEM_RDEN1(rden1), .MEM_ADDR1(addr1), .MEM_DOUT1(d1_a),
    .MEM_REQ2(req), .MEM_WE2(we), .MEM_ADDR2(addr2), .MEM_DIN2(din2), .MEM_SIZE(size),
    .MEM_SIGN(sign), .MEM_BUSY2(busy_a), .MEM_ACK2(ack_a), .MEM_DOUT2(dout_a),
    .IO_IN(io_in), .IO_WR(iowr_a)
`ifdef OTTER_MEM_ERR_EN
    , .MEM_ERR(err_a)
`endif
  );
  otter_mem_hs #(.WAIT_STATES(3)) dut_b (
    .MEM_CLK(clk), .MEM_RST(rst), .MEM_RDEN1(rden1), .MEM_ADDR1(addr1), .MEM_DOUT1(d1_b),
    .MEM_REQ2(req), .MEM_WE2(we), .MEM_ADDR2(addr2), .MEM_DIN2(din2), .MEM_SIZE(size),
    .MEM_SIGN(sign), .MEM_BUSY2(busy_b), .MEM_ACK2(ack_b), .MEM_DOUT2(dout_b),
    .IO_IN(io_in), .IO_WR(iowr_b)
`ifdef OTTER_MEM_ERR_EN
    , .MEM_ERR(err_b)
`endif
  );
`ifndef OTTER_MEM_ERR_EN
  assign err_a = 1'b0;
  assign err_b = 1'b0;
`endif
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // one transaction; inputs are scrambled after acceptance to prove the captured copies are used
  task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s, input logic sg);
    @(negedge clk);
    req = 1; we = w; addr2 = a; din2 = d; size = s; sign = sg;
    @(posedge clk);
    #1;
    req = 0; we = ~w; addr2 = 32'h0; din2 = 32'hFFFF_FFFF; size = 2'd3; sign = ~sg;
    r_la = -1; r_lb = -1; r_ba = 0; r_bb = 0; r_ia = 0; r_ib = 0; r_ica = -1; r_icb = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      p1a[c] = d1_a;
      p1b[c] = d1_b;
      r_ba += int'(busy_a);
      r_bb += int'(busy_b);
      if (ack_a && r_la < 0) begin r_la = c; r_da = dout_a; r_ea = err_a; end
      if (ack_b && r_lb < 0) begin r_lb = c; r_db = dout_b; r_eb = err_b; end
      if (iowr_a) begin r_ia++; r_ica = c; end
      if (iowr_b) begin r_ib++; r_icb = c; end
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dout1", d1_a, 32'h0);
    chk("rst_dout2", {dout_a | dout_b}, 32'h0);
    chk("rst_ctl", {28'h0, busy_a | busy_b, ack_a | ack_b, iowr_a | iowr_b, err_a | err_b}, 32'h0);
    rst = 0;
    acc(1, 32'h100, 32'hDEAD_BEEF, 2'd2, 0);
    chk("sw_lat0", r_la, 2);
    chk("sw_lat3", r_lb, 5);
    chk("sw_iowr", r_ia + r_ib, 0);
    acc(0, 32'h100, 32'h0, 2'd2, 0);
    chk("lw_a", r_da, 32'hDEAD_BEEF);
    chk("lw_b", r_db, 32'hDEAD_BEEF);
    chk("lw_lat0", r_la, 2);
    chk("busy0", r_ba, 2);
    acc(1, 32'h100, 32'h80FF_0000, 2'd2, 0);
    acc(0, 32'h103, 32'h0, 2'd0, 0);
    chk("lb_a", r_da, 32'hFFFF_FF80);
    chk("lb_b", r_db, 32'hFFFF_FF80);
    chk("lb_lat3", r_lb, 5);
    chk("busy3", r_bb, 5);
    acc(0, 32'h103, 32'h0, 2'd0, 1);
    chk("lbu", r_db, 32'h0000_0080);
    acc(0, 32'h102, 32'h0, 2'd1, 0);
    chk("lh", r_da, 32'hFFFF_80FF);
    acc(1, 32'h100, 32'h1122_3344, 2'd2, 0);
    acc(1, 32'h102, 32'h0000_ABCD, 2'd1, 0);
    acc(0, 32'h100, 32'h0, 2'd2, 0);
    chk("sh_word", r_db, 32'hABCD_3344);
    acc(0, 32'h102, 32'h0, 2'd1, 1);
    chk("lhu", r_da, 32'h0000_ABCD);
    acc(0, 32'h102, 32'h0, 2'd1, 0);
    chk("lh_neg", r_db, 32'hFFFF_ABCD);
    acc(1, 32'h101, 32'h0000_005A, 2'd0, 0);
    acc(0, 32'h100, 32'h0, 2'd2, 0);
    chk("sb_word", r_da, 32'hABCD_5A44);
    acc(1, 32'h101, 32'h0000_1234, 2'd1, 0);
    acc(0, 32'h100, 32'h0, 2'd2, 0);
    chk("sh_off1", r_db, 32'hAB12_3444);
    acc(0, 32'h101, 32'h0, 2'd1, 1);
    chk("lhu_off1", r_da, 32'h0000_1234);
    acc(1, 32'h104, 32'hCAFE_F00D, 2'd2, 0);
    acc(1, 32'h0001_0004, 32'h5, 2'd2, 0);
    chk("iowr_cnt0", r_ia, 1);
    chk("iowr_cnt3", r_ib, 1);
    chk("iowr_cyc0", r_ica, 1);
    chk("iowr_cyc3", r_icb, 4);
    chk("io_st_ack", r_lb, 5);
    acc(0, 32'h104, 32'h0, 2'd2, 0);
    chk("io_ram_a", r_da, 32'hCAFE_F00D);
    chk("io_ram_b", r_db, 32'hCAFE_F00D);
    io_in = 32'h77;
    acc(0, 32'h0001_0000, 32'h0, 2'd2, 0);
    chk("io_ld_a", r_da, 32'h77);
    chk("io_ld_b", r_db, 32'h77);
    chk("io_ld_nowr", r_ia + r_ib, 0);
    io_in = 32'h0;
    acc(0, 32'h100, 32'h0, 2'd2, 0);
    acc(1, 32'h103, 32'h0000_FFFF, 2'd1, 0);
    chk("bad_st_ack", r_la, 2);
    chk("bad_st_dout", r_db, 32'hAB12_3444);
`ifdef OTTER_MEM_ERR_EN
    chk("bad_st_err", {31'h0, r_ea & r_eb}, 32'h1);
`endif
    acc(0, 32'h100, 32'h0, 2'd2, 0);
    chk("bad_st_ram", r_da, 32'hAB12_3444);
`ifdef OTTER_MEM_ERR_EN
    chk("ok_noerr", {31'h0, r_ea | r_eb}, 32'h0);
`endif
    acc(0, 32'h103, 32'h0, 2'd1, 0);
    chk("bad_ld", r_db, 32'h0);
    @(negedge clk);
    req = 1; we = 1; addr2 = 32'h100; din2 = 32'h9999_9999; size = 2'd2; sign = 0;
    @(posedge clk);
    #1 req = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_busy", {31'h0, busy_b}, 32'h0);
    chk("mid_rst_dout", dout_b, 32'h0);
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acks += int'(ack_b);
    end
    chk("mid_rst_noack", acks, 0);
    acc(0, 32'h100, 32'h0, 2'd2, 0);
    chk("mid_rst_ram_b", r_db, 32'hAB12_3444);
    chk("mid_rst_ram_a", r_da, 32'h9999_9999);
    chk("mid_rst_lat", r_lb, 5);
    rden1 = 1;
    addr1 = 14'h40;
    acc(1, 32'h100, 32'h1357_9BDF, 2'd2, 0);
    chk("p1_old_a", p1a[2], 32'h9999_9999);
    chk("p1_new_a", p1a[3], 32'h1357_9BDF);
    chk("p1_old_b", p1b[5], 32'hAB12_3444);
    chk("p1_new_b", p1b[6], 32'h1357_9BDF);
    rden1 = 0;
    addr1 = 14'h41;
    repeat (2) @(negedge clk);
    chk("p1_hold", d1_a, 32'h1357_9BDF);
    rden1 = 1;
    repeat (2) @(negedge clk);
    chk("p1_rd", d1_b, 32'hCAFE_F00D);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
